unidade_controle_jogo: RTL and testbench

- Moore FSM controller that sequences the memory-game datapath: address counter (E), round-limit counter (L), play register (R), ROM comparator.
- Also owns the per-play timeout counter.
- Sits beside the datapath inside the game top level.
- Drives the counter and register controls plus the end-of-game flags (pronto / acertou / errou / timeout) and a 4-bit state code for the hex debug display.

---
 rtl/unidade_controle_jogo_if.sv | 33 +++
 rtl/unidade_controle_jogo.sv | 171 +++++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the memory-game controller (master) and the
// datapath plus player inputs (slave).
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualLimite;
  logic       fimL;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;
  logic       db_timeout_ativo;

  modport master (
    input  iniciar, jogada, igual, enderecoIgualLimite, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
    output pronto, acertou, errou, timeout, db_estado, db_timeout_ativo
  );

  modport slave (
    output iniciar, jogada, igual, enderecoIgualLimite, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
    input  pronto, acertou, errou, timeout, db_estado, db_timeout_ativo
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore controller for the memory game: sequences the E/L counters, play register and end flags.
// Macro JOGO_TIMEOUT_EN adds the per-play timeout counter and the fim_timeout state.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CYCLES = 3000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.master io_ctl
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  estado_t r_estado;
  estado_t w_estado_prox;

  logic r_zeraE;
  logic r_contaE;
  logic r_zeraL;
  logic r_contaL;
  logic r_zeraR;
  logic r_registraR;
  logic r_pronto;
  logic r_acertou;
  logic r_errou;
  logic r_timeout;
  logic r_db_timeout_ativo;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || TIMEOUT_W < 1 ||
      ((TIMEOUT_CYCLES - 1) >> TIMEOUT_W) != 0) begin : g_parametros_invalidos
    $error("unidade_controle_jogo: TIMEOUT_CYCLES/TIMEOUT_W out of range");
  end

`ifdef JOGO_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] L_ULTIMO_CICLO = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_contador;
  logic                 w_fim_contagem;

  assign w_fim_contagem = (r_contador == L_ULTIMO_CICLO);

  // Counts only while staying in espera_jogada, so every entry starts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_contador <= '0;
    end else if (r_estado == ESPERA_JOGADA && w_estado_prox == ESPERA_JOGADA) begin
      if (r_contador != '1) begin
        r_contador <= r_contador + TIMEOUT_W'(1);
      end
    end else begin
      r_contador <= '0;
    end
  end
`endif

  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      INICIAL: begin
        if (io_ctl.iniciar) begin
          w_estado_prox = PREPARACAO;
        end
      end
      PREPARACAO:     w_estado_prox = INICIO_RODADA;
      INICIO_RODADA:  w_estado_prox = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A play arriving on the terminal count still wins over the timeout.
        if (io_ctl.jogada) begin
          w_estado_prox = REGISTRA;
        end
`ifdef JOGO_TIMEOUT_EN
        else if (w_fim_contagem) begin
          w_estado_prox = FIM_TIMEOUT;
        end
`endif
      end
      REGISTRA:       w_estado_prox = COMPARACAO;
      COMPARACAO: begin
        if (!io_ctl.igual) begin
          w_estado_prox = FIM_ERROU;
        end else if (!io_ctl.enderecoIgualLimite) begin
          w_estado_prox = PROXIMA_JOGADA;
        end else if (!io_ctl.fimL) begin
          w_estado_prox = PROXIMA_RODADA;
        end else begin
          w_estado_prox = FIM_ACERTOU;
        end
      end
      PROXIMA_JOGADA: w_estado_prox = ESPERA_JOGADA;
      PROXIMA_RODADA: w_estado_prox = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU: begin
        if (io_ctl.iniciar) begin
          w_estado_prox = PREPARACAO;
        end
      end
`ifdef JOGO_TIMEOUT_EN
      FIM_TIMEOUT: begin
        if (io_ctl.iniciar) begin
          w_estado_prox = PREPARACAO;
        end
      end
`endif
      default:        w_estado_prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado           <= INICIAL;
      r_zeraE            <= 1'b0;
      r_contaE           <= 1'b0;
      r_zeraL            <= 1'b0;
      r_contaL           <= 1'b0;
      r_zeraR            <= 1'b0;
      r_registraR        <= 1'b0;
      r_pronto           <= 1'b0;
      r_acertou          <= 1'b0;
      r_errou            <= 1'b0;
      r_timeout          <= 1'b0;
      r_db_timeout_ativo <= 1'b0;
    end else begin
      r_estado    <= w_estado_prox;
      r_zeraE     <= (w_estado_prox == PREPARACAO) || (w_estado_prox == INICIO_RODADA);
      r_contaE    <= (w_estado_prox == PROXIMA_JOGADA);
      r_zeraL     <= (w_estado_prox == PREPARACAO);
      r_contaL    <= (w_estado_prox == PROXIMA_RODADA);
      r_zeraR     <= (w_estado_prox == PREPARACAO);
      r_registraR <= (w_estado_prox == REGISTRA);
      r_acertou   <= (w_estado_prox == FIM_ACERTOU);
`ifdef JOGO_TIMEOUT_EN
      r_pronto           <= (w_estado_prox == FIM_ACERTOU) || (w_estado_prox == FIM_ERROU) ||
                            (w_estado_prox == FIM_TIMEOUT);
      r_errou            <= (w_estado_prox == FIM_ERROU) || (w_estado_prox == FIM_TIMEOUT);
      r_timeout          <= (w_estado_prox == FIM_TIMEOUT);
      r_db_timeout_ativo <= (w_estado_prox == ESPERA_JOGADA);
`else
      r_pronto           <= (w_estado_prox == FIM_ACERTOU) || (w_estado_prox == FIM_ERROU);
      r_errou            <= (w_estado_prox == FIM_ERROU);
      r_timeout          <= 1'b0;
      r_db_timeout_ativo <= 1'b0;
`endif
    end
  end

  assign io_ctl.zeraE            = r_zeraE;
  assign io_ctl.contaE           = r_contaE;
  assign io_ctl.zeraL            = r_zeraL;
  assign io_ctl.contaL           = r_contaL;
  assign io_ctl.zeraR            = r_zeraR;
  assign io_ctl.registraR        = r_registraR;
  assign io_ctl.pronto           = r_pronto;
  assign io_ctl.acertou          = r_acertou;
  assign io_ctl.errou            = r_errou;
  assign io_ctl.timeout          = r_timeout;
  assign io_ctl.db_estado        = r_estado;
  assign io_ctl.db_timeout_ativo = r_db_timeout_ativo;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo: a game-rule model predicts controller events,
// a negedge monitor pops and compares them; direct checks cover reset, latency and boundaries.
`timescale 1ns/1ps
module tb_unidade_controle_jogo;

  localparam int TO_CYCLES = 20;
  localparam int EV_PREP = 0, EV_E = 1, EV_L = 2, EV_A = 3, EV_R = 4, EV_T = 5;

`ifdef JOGO_TIMEOUT_EN
  localparam logic TA = 1'b1;
`else
  localparam logic TA = 1'b0;
`endif

  // {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout, db_timeout_ativo}
  localparam logic [14:0] O_PREP = {4'h1, 6'b101010, 5'b00000};
  localparam logic [14:0] O_REG  = {4'h4, 6'b000001, 5'b00000};
  localparam logic [14:0] O_COMP = {4'h5, 6'b000000, 5'b00000};
  localparam logic [14:0] O_ESP  = {4'h3, 6'b000000, 4'b0000, TA};
  localparam logic [14:0] O_ACC  = {4'hA, 6'b000000, 5'b11000};
  localparam logic [14:0] O_ERR  = {4'hE, 6'b000000, 5'b10100};
  localparam logic [14:0] O_TO   = {4'hD, 6'b000000, 5'b10110};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_jogo_if ifc();

  unidade_controle_jogo #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .TIMEOUT_W     (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io_ctl(ifc.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Datapath environment: E, L, R registers and the ROM.
  logic [3:0] rom [16];
  logic [3:0] dp_e, dp_l, dp_r, chaves;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      dp_e <= 4'd0;
      dp_l <= 4'd0;
      dp_r <= 4'd0;
    end else begin
      if (ifc.zeraE) dp_e <= 4'd0;
      else if (ifc.contaE) dp_e <= dp_e + 4'd1;
      if (ifc.zeraL) dp_l <= 4'd0;
      else if (ifc.contaL) dp_l <= dp_l + 4'd1;
      if (ifc.zeraR) dp_r <= 4'd0;
      else if (ifc.registraR) dp_r <= chaves;
    end
  end

  assign ifc.igual               = (dp_r == rom[dp_e]);
  assign ifc.enderecoIgualLimite = (dp_e == dp_l);
  assign ifc.fimL                = (dp_l == 4'd15);

  // Game-rule reference model.
  int q[$];
  int m_round;
  int m_pos;

  function automatic void ref_play(input logic [3:0] v);
    if (v != rom[m_pos]) begin
      q.push_back(EV_R);
    end else if (m_pos < m_round - 1) begin
      q.push_back(EV_E);
      m_pos++;
    end else if (m_round < 16) begin
      q.push_back(EV_L);
      m_round++;
      m_pos = 0;
    end else begin
      q.push_back(EV_A);
    end
  endfunction

  function automatic logic [3:0] codigo_evento(input int k);
    case (k)
      EV_PREP: return 4'h1;
      EV_E:    return 4'h6;
      EV_L:    return 4'h7;
      EV_A:    return 4'hA;
      EV_R:    return 4'hE;
      EV_T:    return 4'hD;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [14:0] outs();
    return {ifc.db_estado, ifc.zeraE, ifc.contaE, ifc.zeraL, ifc.contaL, ifc.zeraR,
            ifc.registraR, ifc.pronto, ifc.acertou, ifc.errou, ifc.timeout, ifc.db_timeout_ativo};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: one scoreboard transaction per controller event.
  logic prev_pronto;
  always @(negedge clock) begin
    int kind;
    int exp_kind;
    if (!reset) begin
      prev_pronto <= 1'b0;
    end else begin
      kind = -1;
      if (ifc.zeraL) kind = EV_PREP;
      else if (ifc.contaE) kind = EV_E;
      else if (ifc.contaL) kind = EV_L;
      else if (ifc.pronto && !prev_pronto)
        kind = ifc.timeout ? EV_T : (ifc.acertou ? EV_A : (ifc.errou ? EV_R : 9));
      prev_pronto <= ifc.pronto;
      if (kind >= 0) begin
        if (q.size() == 0) begin
          check("evento_inesperado", kind, 32'hFFFF_FFFF);
        end else begin
          exp_kind = q.pop_front();
          check("evento", kind, exp_kind);
          check("estado_evento", ifc.db_estado, codigo_evento(exp_kind));
          $display("evento %0d estado %h E=%0d L=%0d t=%0t", kind, ifc.db_estado, dp_e, dp_l, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start();
    foreach (rom[i]) rom[i] = 4'($urandom);
    ifc.iniciar = 1'b1;
    q.push_back(EV_PREP);
    m_round = 1;
    m_pos   = 0;
    tick();
    ifc.iniciar = 1'b0;
    check("preparacao", outs(), O_PREP);
  endtask

  task automatic wait_espera();
    int n;
    n = 0;
    while (ifc.db_estado != 4'h3 && n < 200) begin
      tick();
      n++;
    end
    check("alcanca_espera", ifc.db_estado, 4'h3);
  endtask

  task automatic pulse_jogada(input logic [3:0] v);
    ref_play(v);
    chaves     = v;
    ifc.jogada = 1'b1;
    tick();
    ifc.jogada = 1'b0;
    check("registra", outs(), O_REG);
  endtask

  task automatic wait_pronto();
    int n;
    n = 0;
    while (!ifc.pronto && n < 60) begin
      tick();
      n++;
    end
    check("alcanca_pronto", ifc.pronto, 1'b1);
  endtask

  task automatic play_game(input int err_r, input int err_p, input int stop_r);
    logic [3:0] v;
    for (int k = 1; k <= 16; k++) begin
      for (int p = 0; p < k; p++) begin
        if (k == stop_r) return;
        wait_espera();
        repeat ($urandom_range(0, 3)) tick();
        v = rom[p];
        if (k == err_r && p == err_p) v = rom[p] ^ 4'($urandom_range(1, 15));
        pulse_jogada(v);
        if (k == err_r && p == err_p) begin
          tick();
          check("comparacao", outs(), O_COMP);
          tick();
          check("fim_errou", outs(), O_ERR);
          repeat (10) tick();
          check("fim_errou_mantido", outs(), O_ERR);
          return;
        end
      end
    end
    wait_pronto();
    check("fim_acertou", outs(), O_ACC);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int r;
    int n;
    ifc.iniciar = 1'b0;
    ifc.jogada  = 1'b0;
    chaves      = 4'd0;
    foreach (rom[i]) rom[i] = 4'($urandom);
    repeat (10) tick();
    check("reset", outs(), 15'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("inicial_apos_reset", outs(), 15'h0);

    // Full correct game, then restart and play again.
    start();
    play_game(-1, -1, 0);
    start();
    play_game(-1, -1, 0);

    // Wrong second play of round 3.
    start();
    play_game(3, 1, 0);

    // Randomized games, some with a wrong play at a random point.
    for (int g = 0; g < 3; g++) begin
      start();
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 16);
        play_game(r, $urandom_range(0, r - 1), 0);
      end else begin
        play_game(-1, -1, 0);
      end
    end

    // iniciar ignored mid-game, then asynchronous reset in round 5.
    start();
    play_game(-1, -1, 5);
    wait_espera();
    ifc.iniciar = 1'b1;
    tick();
    ifc.iniciar = 1'b0;
    check("iniciar_ignorado", outs(), O_ESP);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("reset_assincrono", outs(), 15'h0);
    check("fila_vazia_reset", q.size(), 0);
    repeat (3) tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("inicial_apos_reset_jogo", outs(), 15'h0);

`ifdef JOGO_TIMEOUT_EN
    start();
    wait_espera();
    q.push_back(EV_T);
    n = 0;
    while (ifc.db_estado == 4'h3 && n < 100) begin
      tick();
      n++;
    end
    check("ciclos_ate_timeout", n, TO_CYCLES);
    check("fim_timeout", outs(), O_TO);

    start();
    wait_espera();
    repeat (TO_CYCLES - 1) tick();
    check("espera_no_limite", outs(), O_ESP);
    pulse_jogada(rom[0]);
    wait_espera();
    q.push_back(EV_T);
    wait_pronto();
    check("fim_timeout_rodada2", outs(), O_TO);
`else
    start();
    wait_espera();
    repeat (5000) tick();
    check("espera_sem_timeout", outs(), O_ESP);
`endif

    repeat (5) tick();
    check("fila_vazia_final", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
